// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM encoding, BCD limits,
// and the digit-index width helper.
package bcd_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    function automatic int idx_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction and
// invalid-digit detection.
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       inv
);

    logic [4:0] w_raw;

    // Binary add, then apply +6 correction when the digit overflows past nine
    always_comb begin
        w_raw = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        if (w_raw > {1'b0, BCD_MAX}) begin
            s  = w_raw[3:0] + BCD_CORR;
            co = 1'b1;
        end else begin
            s  = w_raw[3:0];
            co = 1'b0;
        end
        inv = (x > BCD_MAX) || (y > BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder/subtractor, least-significant digit first,
// with a start/busy/done handshake and registered outputs.
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = idx_width(DIGITS);
    // ADD covers digits 0..DIGITS-2; the final digit is processed in DONE,
    // whose exit edge loads the result registers.
    localparam logic [IDX_W-1:0] LAST_ADD_IDX = IDX_W'((DIGITS > 1) ? (DIGITS - 2) : 0);

    state_t           r_state;
    state_t           w_state_next;
    logic             w_load;
    logic             w_step;
    logic             w_finish;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_sub;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_acc;
    logic             r_err;

    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_err_o;

    logic [W-1:0]     w_a_shift;
    logic [W-1:0]     w_b_shift;
    logic [3:0]       w_x;
    logic [3:0]       w_b_dig;
    logic [3:0]       w_y;
    logic [3:0]       w_dsum;
    logic             w_co;
    logic             w_inv;
    logic             w_err_any;
    logic [W-1:0]     w_acc_next;

    assign w_a_shift = r_a >> {r_idx, 2'b00};
    assign w_b_shift = r_b >> {r_idx, 2'b00};
    assign w_x       = w_a_shift[3:0];
    assign w_b_dig   = w_b_shift[3:0];
    assign w_y       = r_sub ? (BCD_MAX - w_b_dig) : w_b_dig;
    assign w_err_any = r_err | w_inv;

    bcd_digit_add u_digit (
        .x   (w_x),
        .y   (w_y),
        .ci  (r_carry),
        .s   (w_dsum),
        .co  (w_co),
        .inv (w_inv)
    );

    // Accumulator image with the current digit written into slot r_idx
    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_acc_next[4*i +: 4] = w_dsum;
            end else begin
                w_acc_next[4*i +: 4] = r_acc[4*i +: 4];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and datapath control strobes
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = (DIGITS == 1) ? ST_DONE : ST_ADD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ADD: begin
                w_step = 1'b1;
                if (r_idx == LAST_ADD_IDX) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_ADD;
                end
            end
            ST_DONE: begin
                w_step       = 1'b1;
                w_finish     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand latch and per-digit accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else if (w_step) begin
            r_acc   <= w_acc_next;
            r_carry <= w_co;
            r_err   <= w_err_any;
            r_idx   <= r_idx + IDX_W'(1);
        end else begin
            r_acc   <= r_acc;
        end
    end

    // Handshake and result output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err_o <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= w_finish;
            if (w_finish) begin
                if (w_err_any) begin
                    r_sum   <= '0;
                    r_cout  <= 1'b0;
                    r_err_o <= 1'b1;
                end else begin
                    r_sum   <= w_acc_next;
                    r_cout  <= w_co;
                    r_err_o <= 1'b0;
                end
            end else begin
                r_sum <= r_sum;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err_o;

endmodule
